// File: rtl/alu_seq_pkg.sv
// Shared definitions for the ALU input sequencer: FSM state codes,
// opcode width and the default operand MSB index.
package alu_seq_pkg;

    localparam int OP_W     = 4;
    localparam int DEF_BITS = 4;
    localparam int STATE_W  = 3;

    typedef enum logic [STATE_W-1:0] {
        LOAD_A  = 3'd0,
        LOAD_B  = 3'd1,
        LOAD_OP = 3'd2,
        EXEC    = 3'd3,
        SHOW    = 3'd4
    } state_t;

    // True in the states where the display shows the latched ALU result.
    function automatic logic shows_result(input state_t s);
        return (s == EXEC) || (s == SHOW);
    endfunction

endpackage

// File: rtl/alu_input_sequencer_btn_edge.sv
// Push-button synchronizer and rising-edge detector.
// All flops reset high so a button already held when reset releases is
// treated as "still pressed" and yields no event until released and
// pressed again. The output is named rise because edge is a keyword.
module btn_edge (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic rise
);

    logic sync1_reg;
    logic sync2_reg;
    logic prev_reg;

    // Two-flop synchronizer followed by a one-sample history flop.
    always_ff @(posedge clk) begin
        if (!rst) begin
            sync1_reg <= 1'b1;
            sync2_reg <= 1'b1;
            prev_reg  <= 1'b1;
        end else begin
            sync1_reg <= btn;
            sync2_reg <= sync1_reg;
            prev_reg  <= sync2_reg;
        end
    end

    // Pulse lasts exactly one cycle per low-to-high transition.
    assign rise = sync2_reg & ~prev_reg;

endmodule

// File: rtl/alu_input_sequencer.sv
// Collects operand A, operand B and an opcode from the switches, one per
// button press, presents them registered to an external ALU, then latches
// the ALU result and flags for display.
module alu_input_sequencer
    import alu_seq_pkg::*;
#(
    parameter int BITS = DEF_BITS
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [BITS:0]   sw,
    input  logic            btn,
    output logic [BITS:0]   a,
    output logic [BITS:0]   b,
    output logic [OP_W-1:0] op,
    input  logic [BITS:0]   y,
    input  logic            c,
    input  logic            v,
    input  logic            n,
    input  logic            z,
    output logic [BITS:0]   disp,
    output logic [3:0]      flags,
    output logic [2:0]      state,
    output logic            done
);

    state_t          state_reg;
    state_t          state_next;
    logic [BITS:0]   a_reg;
    logic [BITS:0]   b_reg;
    logic [BITS:0]   y_reg;
    logic [OP_W-1:0] op_reg;
    logic [3:0]      flags_reg;
    logic            press;
    logic            load_a;
    logic            load_b;
    logic            load_op;
    logic            latch_result;

    btn_edge u_btn_edge (
        .clk  (clk),
        .rst  (rst),
        .btn  (btn),
        .rise (press)
    );

    // State register; reset always wins over a coincident press.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg <= LOAD_A;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state and capture-enable decode.
    always_comb begin
        state_next   = state_reg;
        load_a       = 1'b0;
        load_b       = 1'b0;
        load_op      = 1'b0;
        latch_result = 1'b0;
        case (state_reg)
            LOAD_A: begin
                if (press) begin
                    load_a     = 1'b1;
                    state_next = LOAD_B;
                end
            end
            LOAD_B: begin
                if (press) begin
                    load_b     = 1'b1;
                    state_next = LOAD_OP;
                end
            end
            LOAD_OP: begin
                if (press) begin
                    load_op    = 1'b1;
                    state_next = EXEC;
                end
            end
            EXEC: begin
                // Presses arriving here are dropped, not queued.
                latch_result = 1'b1;
                state_next   = SHOW;
            end
            SHOW: begin
                if (press) begin
                    state_next = LOAD_A;
                end
            end
            default: begin
                state_next = LOAD_A;
            end
        endcase
    end

    // Operand, opcode and result registers; operands persist across runs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            a_reg     <= '0;
            b_reg     <= '0;
            op_reg    <= '0;
            y_reg     <= '0;
            flags_reg <= '0;
        end else begin
            if (load_a) begin
                a_reg <= sw;
            end
            if (load_b) begin
                b_reg <= sw;
            end
            if (load_op) begin
                op_reg <= sw[OP_W-1:0];
            end
            if (latch_result) begin
                y_reg     <= y;
                flags_reg <= {c, v, n, z};
            end
        end
    end

    assign a     = a_reg;
    assign b     = b_reg;
    assign op    = op_reg;
    assign flags = flags_reg;
    assign state = state_reg;
    assign done  = (state_reg == EXEC);
    assign disp  = shows_result(state_reg) ? y_reg : sw;

endmodule

// File: tb/tb_alu_input_sequencer.sv
// Randomized bench for alu_input_sequencer with a cycle-level behavioural
// model, a stub ALU, and directed scenarios with literal expectations.
module tb_alu_input_sequencer;
    import alu_seq_pkg::*;

    localparam int BITS = 4;
    localparam int W    = BITS + 1;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         btn = 1'b0;
    logic [W-1:0] sw  = '0;
    logic [W-1:0] a, b, y, disp;
    logic [3:0]   op, flags;
    logic [2:0]   state;
    logic         done, c, v, n, z;

    int errors = 0;
    int checks = 0;
    int done_cnt = 0;
    bit suspend = 1'b0;

    alu_input_sequencer #(.BITS(BITS)) dut (
        .clk(clk), .rst(rst), .sw(sw), .btn(btn),
        .a(a), .b(b), .op(op), .y(y), .c(c), .v(v), .n(n), .z(z),
        .disp(disp), .flags(flags), .state(state), .done(done)
    );

    always #5 clk = ~clk;

    // Stub ALU: y = a + b (wrapping), c = carry out, v = op[0],
    // n = bit BITS-1 of y, z = (y == 0). Returns {y, c, v, n, z}.
    function automatic logic [W+3:0] alu_f(input logic [W-1:0] aa, input logic [W-1:0] bb,
                                           input logic [3:0] oo);
        logic [W:0]   sum;
        logic [W-1:0] yy;
        sum = {1'b0, aa} + {1'b0, bb};
        yy  = sum[W-1:0];
        return {yy, sum[W], oo[0], yy[BITS-1], (yy == '0)};
    endfunction

    assign {y, c, v, n, z} = alu_f(a, b, op);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // The button event at clock edge k fires when btn was sampled high at
    // edge k-2 and low at edge k-3; reset makes all past samples read high.
    int           m_st = 0;
    logic [W-1:0] m_a = '0, m_b = '0, m_y = '0;
    logic [3:0]   m_op = '0, m_fl = '0;
    logic [2:0]   hist = 3'b111;   // hist[0]=btn(k-1), [1]=btn(k-2), [2]=btn(k-3)
    bit           m_valid = 1'b0;

    always @(posedge clk) begin
        logic ev;
        logic [W+3:0] r;
        if (!rst) begin
            m_st    <= 0;
            m_a     <= '0;
            m_b     <= '0;
            m_op    <= '0;
            m_y     <= '0;
            m_fl    <= '0;
            hist    <= 3'b111;
            m_valid <= 1'b1;
        end else begin
            ev   = hist[1] & ~hist[2];
            hist <= {hist[1:0], btn};
            r    = alu_f(m_a, m_b, m_op);
            if (m_st == 0 && ev) begin m_a <= sw; m_st <= 1; end
            else if (m_st == 1 && ev) begin m_b <= sw; m_st <= 2; end
            else if (m_st == 2 && ev) begin m_op <= sw[3:0]; m_st <= 3; end
            else if (m_st == 3) begin m_y <= r[W+3:4]; m_fl <= r[3:0]; m_st <= 4; end
            else if (m_st == 4 && ev) begin m_st <= 0; end
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (m_valid && !suspend) begin
            check("state", 32'(state), 32'(m_st));
            check("a", 32'(a), 32'(m_a));
            check("b", 32'(b), 32'(m_b));
            check("op", 32'(op), 32'(m_op));
            check("flags", 32'(flags), 32'(m_fl));
            check("done", 32'(done), 32'(m_st == 3));
            check("disp", 32'(disp), 32'((m_st == 3 || m_st == 4) ? m_y : sw));
        end
        if (done === 1'b1) done_cnt++;
    end

    task automatic cyc(input int k);
        repeat (k) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic press(input int hold, input int gap);
        btn = 1'b1;
        cyc(hold);
        btn = 1'b0;
        cyc(gap);
    endtask

    int d0;

    initial begin
        // Reset held with the button pressed.
        rst = 1'b0;
        btn = 1'b1;
        sw  = 5'h03;
        cyc(3);
        check("rst_state", 32'(state), 32'd0);
        check("rst_a", 32'(a), 32'd0);
        check("rst_flags", 32'(flags), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        rst = 1'b1;
        cyc(20);
        check("held_state", 32'(state), 32'd0);
        check("held_a", 32'(a), 32'd0);
        btn = 1'b0;
        cyc(4);
        press(4, 4);
        check("first_press_state", 32'(state), 32'd1);

        // Full operand/opcode sequence.
        sw = 5'h05;
        press(4, 4);
        sw = 5'h02;
        d0 = done_cnt;
        press(4, 4);
        check("seq_a", 32'(a), 32'h03);
        check("seq_b", 32'(b), 32'h05);
        check("seq_op", 32'(op), 32'h2);
        check("seq_disp", 32'(disp), 32'h08);
        check("seq_flags", 32'(flags), 32'b0010);
        check("seq_state", 32'(state), 32'd4);
        check("seq_done_pulses", 32'(done_cnt - d0), 32'd1);

        // New run from SHOW: only A changes.
        press(3, 4);
        check("show_to_loada", 32'(state), 32'd0);
        sw = 5'h1F;
        press(2, 4);
        check("rerun_a", 32'(a), 32'h1F);
        check("rerun_b", 32'(b), 32'h05);
        check("rerun_op", 32'(op), 32'h2);
        sw = 5'h0A;
        cyc(1);
        check("disp_follows_sw", 32'(disp), 32'h0A);

        // Back to LOAD_A, then one long press: capture on the 3rd edge.
        press(2, 4);
        press(2, 4);
        press(2, 4);
        check("back_loada", 32'(state), 32'd0);
        sw = 5'h16;
        btn = 1'b1;
        cyc(2);
        check("long_press_edge2", 32'(state), 32'd0);
        cyc(1);
        check("long_press_edge3", 32'(state), 32'd1);
        check("long_press_a", 32'(a), 32'h16);
        cyc(47);
        check("long_press_single", 32'(state), 32'd1);
        btn = 1'b0;
        cyc(4);

        // Reset coinciding with the LOAD_OP capture edge.
        press(2, 4);
        check("at_loadop", 32'(state), 32'd2);
        d0 = done_cnt;
        btn = 1'b1;
        cyc(2);
        rst = 1'b0;
        cyc(1);
        check("rst_edge_state", 32'(state), 32'd0);
        check("rst_edge_a", 32'(a), 32'd0);
        check("rst_edge_b", 32'(b), 32'd0);
        check("rst_edge_op", 32'(op), 32'd0);
        rst = 1'b1;
        cyc(5);
        check("rst_edge_no_done", 32'(done_cnt - d0), 32'd0);
        check("rst_edge_hold", 32'(state), 32'd0);
        btn = 1'b0;
        cyc(4);

        // Illegal state code recovers to LOAD_A.
        suspend = 1'b1;
        @(negedge clk);
        force dut.state_reg = state_t'(3'd6);
        #1;
        release dut.state_reg;
        @(posedge clk);
        #1;
        check("illegal_state_recover", 32'(state), 32'd0);
        suspend = 1'b0;
        cyc(2);

        // Randomized presses, switch changes and occasional resets.
        for (int i = 0; i < 300; i++) begin
            sw = W'($urandom);
            if ($urandom_range(0, 19) == 0) begin
                rst = 1'b0;
                if ($urandom_range(0, 1) == 1) btn = 1'b1;
                cyc($urandom_range(1, 3));
                rst = 1'b1;
                cyc($urandom_range(1, 4));
                btn = 1'b0;
                cyc(1);
            end else begin
                btn = 1'b1;
                cyc($urandom_range(1, 10));
                sw = W'($urandom);
                btn = 1'b0;
                cyc($urandom_range(1, 6));
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
